// File: rtl/spi_target_pkg.sv
// Shared constants for the SPI target: idle/underrun fill byte, synchronizer
// depth and bit-counter width.
package spi_target_pkg;

   localparam logic [7:0] DUMMY_DEF   = 8'hFF;
   localparam int         SYNC_STAGES = 2;
   localparam int         BITCNT_W    = 3;

endpackage

// File: rtl/spi_target_fifo.sv
// Small synchronous FIFO with a registered occupancy count. Push while full is
// accepted only when a pop happens in the same cycle.
module spi_target_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/spi_target.sv
// SPI target, modes 0 and 3, MSB first, 8-bit frames. SCK, MOSI and nSS are
// oversampled by CLK; received and transmitted bytes pass through FIFOs.
module spi_target
   import spi_target_pkg::*;
#(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] DUMMY      = DUMMY_DEF
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       SCK_IN,
   input  logic       MOSI_IN,
   input  logic       nSS_IN,
   output logic       MISO_OUT,
   output logic       MISO_OE,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   input  logic       RX_READY,
   input  logic [7:0] TX_DATA,
   input  logic       TX_VALID,
   output logic       TX_READY,
   output logic       FRAME_START,
   output logic       FRAME_END,
   output logic       RX_OVERRUN,
   output logic       TX_UNDERRUN,
   input  logic       CLR_FLAGS
);

   logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, nss_sync;
   logic                   sck_d, nss_d;
   logic                   sck_s, mosi_s, nss_s;
   logic                   sel;
   logic                   seen_rise;
   logic [BITCNT_W-1:0]    bitcnt;
   logic [7:0]             rxsr, txsr;
   logic                   sck_rise, sck_fall, nss_fall, nss_rise;
   logic                   byte_done, tx_load, tx_pop;
   logic [7:0]             tx_head, tx_next, rx_byte;
   logic                   tx_full, tx_empty, rx_full, rx_empty;
   logic                   rx_pop, rx_drop;

   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign nss_s  = nss_sync[SYNC_STAGES-1];

   // The select chain resets to "low" so a select already asserted across
   // reset never looks like a fresh fall; sel only rises on a real 1->0 edge.
   assign sck_rise  = sel && sck_s && !sck_d;
   assign sck_fall  = sel && !sck_s && sck_d;
   assign nss_fall  = nss_d && !nss_s;
   assign nss_rise  = sel && nss_s && !nss_d;
   assign byte_done = sck_rise && (bitcnt == '1);
   assign tx_load   = nss_fall || byte_done;
   assign tx_pop    = tx_load && !tx_empty;
   assign tx_next   = tx_empty ? DUMMY : tx_head;
   assign rx_byte   = {rxsr[6:0], mosi_s};
   assign rx_pop    = RX_VALID && RX_READY;
   assign rx_drop   = byte_done && rx_full && !rx_pop;
   assign RX_VALID  = !rx_empty;
   assign TX_READY  = !tx_full;

   // Two-stage synchronizers plus one delay stage for edge detection.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         nss_sync  <= '0;
         sck_d     <= 1'b0;
         nss_d     <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK_IN};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI_IN};
         nss_sync  <= {nss_sync[SYNC_STAGES-2:0], nSS_IN};
         sck_d     <= sck_s;
         nss_d     <= nss_s;
      end
   end

   // Frame tracking, bit counter and both shift registers.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         sel       <= 1'b0;
         seen_rise <= 1'b0;
         bitcnt    <= '0;
         rxsr      <= '0;
         txsr      <= '0;
      end else if (nss_fall) begin
         sel       <= 1'b1;
         seen_rise <= 1'b0;
         bitcnt    <= '0;
         txsr      <= tx_next;
      end else if (nss_rise) begin
         sel       <= 1'b0;
         seen_rise <= 1'b0;
         bitcnt    <= '0;
      end else if (sck_rise) begin
         rxsr   <= rx_byte;
         bitcnt <= bitcnt + BITCNT_W'(1);
         if (byte_done) begin
            txsr      <= tx_next;
            seen_rise <= 1'b0;
         end else begin
            seen_rise <= 1'b1;
         end
      end else if (sck_fall && seen_rise) begin
         txsr <= {txsr[6:0], 1'b0};
      end
   end

   // Registered pad-side outputs and frame pulses; MISO holds while deselected.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         MISO_OUT    <= 1'b1;
         MISO_OE     <= 1'b0;
         FRAME_START <= 1'b0;
         FRAME_END   <= 1'b0;
      end else begin
         if (sel) MISO_OUT <= txsr[7];
         MISO_OE     <= sel;
         FRAME_START <= nss_fall;
         FRAME_END   <= nss_rise;
      end
   end

   // Sticky error flags; a clear wins over a same-cycle set.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         RX_OVERRUN  <= 1'b0;
         TX_UNDERRUN <= 1'b0;
      end else begin
         if (CLR_FLAGS)    RX_OVERRUN <= 1'b0;
         else if (rx_drop) RX_OVERRUN <= 1'b1;
         if (CLR_FLAGS)                  TX_UNDERRUN <= 1'b0;
         else if (tx_load && tx_empty)   TX_UNDERRUN <= 1'b1;
      end
   end

   spi_target_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk       (CLK),
      .nrst      (nRST),
      .push      (byte_done),
      .push_data (rx_byte),
      .pop       (rx_pop),
      .head      (RX_DATA),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   spi_target_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (CLK),
      .nrst      (nRST),
      .push      (TX_VALID && TX_READY),
      .push_data (TX_DATA),
      .pop       (tx_pop),
      .head      (tx_head),
      .full      (tx_full),
      .empty     (tx_empty)
   );

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a bit-banged SPI master drives directed frames; an RX
// monitor compares every popped byte against a queue of expected bytes.
module tb_spi_target;

   localparam int H = 8;

   logic       CLK = 1'b0;
   logic       nRST = 1'b0;
   logic       SCK_IN = 1'b0;
   logic       MOSI_IN = 1'b0;
   logic       nSS_IN = 1'b1;
   logic       RX_READY = 1'b0;
   logic [7:0] TX_DATA = 8'h00;
   logic       TX_VALID = 1'b0;
   logic       CLR_FLAGS = 1'b0;
   logic       MISO_OUT, MISO_OE, RX_VALID, TX_READY;
   logic       FRAME_START, FRAME_END, RX_OVERRUN, TX_UNDERRUN;
   logic [7:0] RX_DATA;

   int         n_checks = 0;
   int         n_err = 0;
   int         n_fs = 0;
   int         n_fe = 0;
   int         fs0, fe0;
   logic [7:0] rx_exp [$];
   logic [7:0] got;

   always #5 CLK = ~CLK;

   spi_target #(.FIFO_DEPTH(4), .DUMMY(8'hFF)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .SCK_IN      (SCK_IN),
      .MOSI_IN     (MOSI_IN),
      .nSS_IN      (nSS_IN),
      .MISO_OUT    (MISO_OUT),
      .MISO_OE     (MISO_OE),
      .RX_DATA     (RX_DATA),
      .RX_VALID    (RX_VALID),
      .RX_READY    (RX_READY),
      .TX_DATA     (TX_DATA),
      .TX_VALID    (TX_VALID),
      .TX_READY    (TX_READY),
      .FRAME_START (FRAME_START),
      .FRAME_END   (FRAME_END),
      .RX_OVERRUN  (RX_OVERRUN),
      .TX_UNDERRUN (TX_UNDERRUN),
      .CLR_FLAGS   (CLR_FLAGS)
   );

   // RX scoreboard monitor and frame pulse counters, sampled mid-cycle.
   always @(negedge CLK) begin
      logic [7:0] e;
      if (nRST) begin
         if (FRAME_START) n_fs++;
         if (FRAME_END)   n_fe++;
         if (RX_VALID && RX_READY) begin
            n_checks++;
            if (rx_exp.size() == 0) begin
               n_err++;
               $display("FAIL rx_unexpected: got %02h, expected no byte", RX_DATA);
            end else begin
               e = rx_exp.pop_front();
               if (RX_DATA !== e) begin
                  n_err++;
                  $display("FAIL rx_data: got %02h, expected %02h", RX_DATA, e);
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tx_push(input logic [7:0] d);
      TX_DATA  = d;
      TX_VALID = 1'b1;
      step(1);
      TX_VALID = 1'b0;
   endtask

   task automatic clr_flags();
      CLR_FLAGS = 1'b1;
      step(1);
      CLR_FLAGS = 1'b0;
   endtask

   task automatic frame_begin(input logic mode3);
      SCK_IN = mode3;
      step(H);
      nSS_IN = 1'b0;
      step(H);
   endtask

   task automatic frame_end();
      step(H);
      nSS_IN = 1'b1;
      step(2*H);
   endtask

   // Master samples MISO just before each rising SCK edge.
   task automatic xfer(input logic mode3, input int nbits, input logic [7:0] data,
                       output logic [7:0] rd);
      rd = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         if (mode3) SCK_IN = 1'b0;
         MOSI_IN = data[7-i];
         step(H);
         rd = {rd[6:0], MISO_OUT};
         SCK_IN = 1'b1;
         step(H);
         if (!mode3) SCK_IN = 1'b0;
      end
   endtask

   task automatic spi_byte(input logic mode3, input logic [7:0] mosi,
                           input logic [7:0] exp_miso, input string nm);
      logic [7:0] rd;
      xfer(mode3, 8, mosi, rd);
      chk(nm, rd, exp_miso);
   endtask

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 100 && rx_exp.size() != 0; i++) step(1);
      chk(nm, rx_exp.size(), 0);
   endtask

   initial begin
      // Reset values
      step(4);
      @(negedge CLK);
      chk("rst_miso", MISO_OUT, 1);
      chk("rst_oe", MISO_OE, 0);
      chk("rst_rx_valid", RX_VALID, 0);
      chk("rst_tx_ready", TX_READY, 1);
      chk("rst_fstart", FRAME_START, 0);
      chk("rst_fend", FRAME_END, 0);
      chk("rst_ovr", RX_OVERRUN, 0);
      chk("rst_und", TX_UNDERRUN, 0);
      @(posedge CLK); #1;
      nRST = 1'b1;
      step(4);

      // Mode 0, single byte, consumer held off
      tx_push(8'hA5);
      rx_exp.push_back(8'h3C);
      frame_begin(1'b0);
      @(negedge CLK);
      chk("s1_oe_sel", MISO_OE, 1);
      spi_byte(1'b0, 8'h3C, 8'hA5, "s1_miso");
      frame_end();
      @(negedge CLK);
      chk("s1_rx_valid", RX_VALID, 1);
      chk("s1_rx_data", RX_DATA, 8'h3C);
      chk("s1_oe_desel", MISO_OE, 0);
      chk("s1_und", TX_UNDERRUN, 1);
      @(posedge CLK); #1;
      RX_READY = 1'b1;
      wait_drain("s1_drain");
      clr_flags();

      // Mode 3, two bytes in one frame
      fs0 = n_fs;
      fe0 = n_fe;
      tx_push(8'h5A);
      tx_push(8'hC3);
      rx_exp.push_back(8'h11);
      rx_exp.push_back(8'h22);
      frame_begin(1'b1);
      spi_byte(1'b1, 8'h11, 8'h5A, "s2_miso0");
      spi_byte(1'b1, 8'h22, 8'hC3, "s2_miso1");
      frame_end();
      wait_drain("s2_drain");
      chk("s2_fstart_cnt", n_fs - fs0, 1);
      chk("s2_fend_cnt", n_fe - fe0, 1);
      clr_flags();

      // Empty TX FIFO: dummy bytes and underrun
      rx_exp.push_back(8'h00);
      rx_exp.push_back(8'hF0);
      frame_begin(1'b0);
      spi_byte(1'b0, 8'h00, 8'hFF, "s3_miso0");
      spi_byte(1'b0, 8'hF0, 8'hFF, "s3_miso1");
      frame_end();
      wait_drain("s3_drain");
      @(negedge CLK);
      chk("s3_und_set", TX_UNDERRUN, 1);
      chk("s3_ovr_clear", RX_OVERRUN, 0);
      @(posedge CLK); #1;
      clr_flags();
      @(negedge CLK);
      chk("s3_und_clr", TX_UNDERRUN, 0);
      @(posedge CLK); #1;

      // RX overrun with a full TX FIFO preloaded
      RX_READY = 1'b0;
      tx_push(8'h10);
      tx_push(8'h20);
      tx_push(8'h30);
      tx_push(8'h40);
      @(negedge CLK);
      chk("s4_tx_full", TX_READY, 0);
      @(posedge CLK); #1;
      for (int i = 1; i <= 4; i++) rx_exp.push_back(8'(i));
      frame_begin(1'b0);
      spi_byte(1'b0, 8'h01, 8'h10, "s4_miso0");
      spi_byte(1'b0, 8'h02, 8'h20, "s4_miso1");
      spi_byte(1'b0, 8'h03, 8'h30, "s4_miso2");
      spi_byte(1'b0, 8'h04, 8'h40, "s4_miso3");
      spi_byte(1'b0, 8'h05, 8'hFF, "s4_miso4");
      frame_end();
      @(negedge CLK);
      chk("s4_ovr", RX_OVERRUN, 1);
      chk("s4_tx_ready", TX_READY, 1);
      @(posedge CLK); #1;
      RX_READY = 1'b1;
      wait_drain("s4_drain");
      clr_flags();
      @(negedge CLK);
      chk("s4_ovr_clr", RX_OVERRUN, 0);
      @(posedge CLK); #1;

      // Partial frame discarded, next frame restarts the bit count
      frame_begin(1'b0);
      xfer(1'b0, 5, 8'hFF, got);
      frame_end();
      rx_exp.push_back(8'h81);
      frame_begin(1'b0);
      spi_byte(1'b0, 8'h81, 8'hFF, "s5_miso");
      frame_end();
      wait_drain("s5_drain");
      step(4);
      @(negedge CLK);
      chk("s5_rx_empty", RX_VALID, 0);
      @(posedge CLK); #1;
      clr_flags();

      // Reset in the middle of a byte
      RX_READY = 1'b0;
      frame_begin(1'b0);
      xfer(1'b0, 8, 8'h42, got);
      xfer(1'b0, 3, 8'hA0, got);
      @(negedge CLK);
      chk("s6_pre_valid", RX_VALID, 1);
      chk("s6_pre_oe", MISO_OE, 1);
      @(posedge CLK); #1;
      nRST = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      chk("s6_miso", MISO_OUT, 1);
      chk("s6_oe", MISO_OE, 0);
      chk("s6_rx_valid", RX_VALID, 0);
      chk("s6_tx_ready", TX_READY, 1);
      chk("s6_fstart", FRAME_START, 0);
      chk("s6_fend", FRAME_END, 0);
      chk("s6_ovr", RX_OVERRUN, 0);
      chk("s6_und", TX_UNDERRUN, 0);
      @(posedge CLK); #1;
      nRST = 1'b1;
      fe0 = n_fe;
      SCK_IN = 1'b0;
      nSS_IN = 1'b1;
      step(2*H);
      chk("s6_no_fend", n_fe - fe0, 0);
      RX_READY = 1'b1;
      tx_push(8'hA5);
      rx_exp.push_back(8'h3C);
      frame_begin(1'b0);
      spi_byte(1'b0, 8'h3C, 8'hA5, "s6_miso_after");
      frame_end();
      wait_drain("s6_drain");

      step(4);
      chk("final_rx_queue", rx_exp.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
